// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU-sharing arbiter: FSM state encoding and default widths.
package alu_share_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_OP_W   = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        EXEC = ST_EXEC,
        RESP = ST_RESP
    } state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above rrPtr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rrPtr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    winner,
    output logic               anyReq
);

    int   idx;
    logic found;

    // rrPtr is always kept below NUM_REQ, so one subtraction is enough to wrap.
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rrPtr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = ID_W'(idx);
            end
        end
    end

    assign anyReq = |req;

endmodule

// File: rtl/alu_share_arbiter.sv
// Owns one combinational ALU and time-shares it between NUM_REQ requesters:
// round-robin accept, one registered execute cycle, then a held response.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int OP_W    = DEF_OP_W,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        reqValid,
    output logic [NUM_REQ-1:0]        reqReady,
    input  logic [NUM_REQ*DATA_W-1:0] reqOperandA,
    input  logic [NUM_REQ*DATA_W-1:0] reqOperandB,
    input  logic [NUM_REQ*OP_W-1:0]   reqAluOp,
    output logic [DATA_W-1:0]         aluOperandA,
    output logic [DATA_W-1:0]         aluOperandB,
    output logic [OP_W-1:0]           aluOp,
    input  logic [DATA_W-1:0]         aluResult,
    output logic                      respValid,
    input  logic                      respReady,
    output logic [DATA_W-1:0]         respResult,
    output logic [ID_W-1:0]           respId,
    output logic                      busy,
    output logic [CNT_W-1:0]          opCount
);

    state_t              state, stateNext;
    logic [ID_W-1:0]     rrPtr, ptrNext, winner;
    logic [NUM_REQ-1:0]  grant;
    logic                anyReq;
    logic [DATA_W-1:0]   opA_p0, opB_p0;
    logic [OP_W-1:0]     aluOp_p0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) uArb (
        .req    (reqValid),
        .rrPtr  (rrPtr),
        .grant  (grant),
        .winner (winner),
        .anyReq (anyReq)
    );

    assign ptrNext = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (anyReq) stateNext = EXEC;
            EXEC:    stateNext = RESP;
            RESP:    if (respReady) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Handshake outputs are forced low while reset is asserted, whatever the state.
    always_comb begin
        reqReady  = (state == IDLE && !rst) ? grant : '0;
        respValid = (state == RESP) && !rst;
        busy      = (state == EXEC || state == RESP) && !rst;
    end

    // Stage p0: accept and register the winning request
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rrPtr    <= '0;
            opA_p0   <= '0;
            opB_p0   <= '0;
            aluOp_p0 <= '0;
            respId   <= '0;
        end else begin
            state <= stateNext;
            if (state == IDLE && anyReq) begin
                opA_p0   <= reqOperandA[int'(winner)*DATA_W +: DATA_W];
                opB_p0   <= reqOperandB[int'(winner)*DATA_W +: DATA_W];
                aluOp_p0 <= reqAluOp[int'(winner)*OP_W +: OP_W];
                respId   <= winner;
                rrPtr    <= ptrNext;
            end
        end
    end

    // Stage p1: capture ALU result and count completed responses
    always_ff @(posedge clk) begin
        if (rst) begin
            respResult <= '0;
            opCount    <= '0;
        end else begin
            if (state == EXEC) respResult <= aluResult;
            if (state == RESP && respReady) opCount <= opCount + CNT_W'(1);
        end
    end

    assign aluOperandA = opA_p0;
    assign aluOperandB = opB_p0;
    assign aluOp       = aluOp_p0;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational SimpleALU between NUM_REQ requesters.
- Each requester uses a valid/ready request channel to submit operandA, operandB and aluOp.
- A round-robin arbiter picks one request, registers it, drives the ALU for one cycle, captures the result and returns it with the requester ID on a valid/ready response channel.
- Sits between the ALU and its clients: the integration-level owner of the ALU.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 4, operand/result width (matches the SimpleALU operands).
- OP_W, 3, aluOp width.
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- reqValid  input  NUM_REQ  per-requester request valid.
- reqReady  output  NUM_REQ  one-hot accept strobe.
- reqOperandA  input  NUM_REQ*DATA_W  packed; requester i occupies bits [i*DATA_W +: DATA_W].
- reqOperandB  input  NUM_REQ*DATA_W  packed, same layout.
- reqAluOp  input  NUM_REQ*OP_W  packed; requester i occupies bits [i*OP_W +: OP_W].
- aluOperandA  output  DATA_W  to the ALU.
- aluOperandB  output  DATA_W  to the ALU.
- aluOp  output  OP_W  to the ALU.
- aluResult  input  DATA_W  from the ALU (combinational).
- respValid  output  1  response valid.
- respReady  input  1  response consumer ready.
- respResult  output  DATA_W  captured ALU result.
- respId  output  ID_W  index of the requester being answered.
- busy  output  1  high in EXEC or RESP.
- opCount  output  CNT_W  completed responses.

Behaviour:
- Reset (rst=1 at a clk edge, any state):
  - FSM to IDLE; rrPtr=0; opCount=0.
  - Operand/op registers, respResult and respId cleared to 0.
  - Any in-flight operation is dropped with no response.
  - reqReady=0, respValid=0 and busy=0 during the reset cycle.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If reqValid!=0, the winner is the first set bit at or after rrPtr, searching upward with wrap-around modulo NUM_REQ.
  - reqReady[winner]=1 combinationally in that cycle; all other bits are 0.
  - At the clk edge: latch the winner's operandA/B/aluOp and the winner ID; rrPtr<=winner+1, wrapping NUM_REQ-1 to 0; go to EXEC.
  - If reqValid==0, stay in IDLE; reqReady=0.
- EXEC (exactly 1 cycle): respResult<=aluResult; go to RESP.
- RESP:
  - respValid=1; respResult and respId held stable.
  - When respValid&&respReady at the edge: opCount<=opCount+1 (wraps at 2^CNT_W); go to IDLE.
  - Stall indefinitely while respReady=0.
- aluOperandA/B and aluOp are always driven from the internal registers (0 after reset). The ALU never sees unregistered requester data.
- reqReady is 0 in EXEC and RESP. At most one reqReady bit is high in any cycle.
- Latency:
  - Accept edge to respValid high: 2 clk.
  - Minimum issue interval: 3 clk per operation (no overlap).
- Requesters must hold reqValid and payload until reqReady. Dropping reqValid before accept simply withdraws the request, with no side effect.
- Payload changes after accept are ignored.
- All aluOp codes 0..2^OP_W-1 are passed through unmodified; the arbiter does not interpret opcodes.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,... No requester waits more than NUM_REQ-1 grants.
- An asserted respReady outside RESP has no effect.

Decomposition:
- Shared package alu_share_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2.
  - Default widths DATA_W=4 and OP_W=3.
- One sub-module: rr_arbiter.
  - Combinational priority search with rotation, parameterised NUM_REQ.
  - Inputs: req vector and rrPtr. Outputs: one-hot grant and winner index.
  - rrPtr and the FSM stay in alu_share_arbiter.

Test Plan (the bench pairs the DUT with a stub ALU: aluResult=(aluOperandA+aluOperandB) mod 16, for every aluOp):
- Single request: req0 with A=10, B=0, op=001, respReady=1.
  - reqReady=0001 in the accept cycle.
  - 2 clk later: respValid=1, respResult=10, respId=0.
  - opCount=1 after the handshake.
- Contention: all four requesters valid from reset, with A=i+1, B=1 (i = requester index), respReady=1.
  - Grants in order 0,1,2,3,0.
  - Responses 2,3,4,5 with respId 0..3.
  - Back-to-back accepts exactly 3 clk apart.
- Backpressure: req2 with A=7, B=9; respReady=0 for 5 cycles.
  - respValid held with result 0, respId=2 stable; busy=1; no reqReady asserted.
  - Completes on the first cycle respReady=1.
- Wrap-around and withdrawal:
  - rrPtr=3 with only req1 valid: req1 is granted; rrPtr becomes 2.
  - req3 raised and dropped before any grant: never granted, no response.
- Reset mid-operation: rst=1 in EXEC with A=15, B=15.
  - Next cycle: IDLE, respValid=0, opCount=0, ALU inputs 0; no response is ever produced for that request.
- Counter wrap: CNT_W=4, 17 operations → opCount=1.
